// File: rtl/irrigation_pkg.sv
// Shared types and defaults for the irrigation actuator sequencer.
package irrigation_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_DRIP  = 3'd1,
    ST_SPRAY = 3'd2,
    ST_DEAD  = 3'd3,
    ST_LOCK  = 3'd4
  } state_e;

  localparam int unsigned DEF_MIN_ON      = 8;
  localparam int unsigned DEF_DEAD        = 2;
  localparam int unsigned DEF_ERR_CONFIRM = 3;
  localparam int unsigned DEF_BLINK_DIV   = 4;

endpackage

// File: rtl/irrigation_sequencer_alarm_blinker.sv
// Alarm lamp blinker: square wave with BLINK_DIV-cycle half-period while en is high,
// first half-period high; cleared whenever en drops.
module alarm_blinker
  import irrigation_pkg::*;
#(
  parameter int unsigned BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic blink
);

  localparam int unsigned CW = $clog2(BLINK_DIV + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;

  // Toggle on every counter wrap; the counter idles at zero so the first enabled edge turns the lamp on.
  always_comb begin
    cnt_d   = '0;
    blink_d = 1'b0;
    if (en) begin
      if (cnt_q == '0) begin
        blink_d = ~blink_q;
        cnt_d   = CNT_LOAD;
      end else begin
        blink_d = blink_q;
        cnt_d   = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/irrigation_sequencer.sv
// Actuator stage: drives drip/spray/inlet valves and alarm lamp with minimum on-time,
// drip<->spray dead-time, confirmed-error lockout and alarm blinking.
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int unsigned MIN_ON      = DEF_MIN_ON,
  parameter int unsigned DEAD        = DEF_DEAD,
  parameter int unsigned ERR_CONFIRM = DEF_ERR_CONFIRM,
  parameter int unsigned BLINK_DIV   = DEF_BLINK_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vs_req,
  input  logic               bs_req,
  input  logic               ve_req,
  input  logic               al_req,
  input  logic               err_in,
  input  logic               vazio_in,
  input  logic               ack,
  output logic               vs_out,
  output logic               bs_out,
  output logic               ve_out,
  output logic               al_out,
  output logic               lockout,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned TMAX = (MIN_ON > DEAD) ? MIN_ON : DEAD;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned EW   = $clog2(ERR_CONFIRM + 1);

  localparam logic [TW-1:0] T_MIN_ON = TW'(MIN_ON - 1);
  localparam logic [TW-1:0] T_DEAD   = TW'(DEAD - 1);
  localparam logic [EW-1:0] E_MAX    = EW'(ERR_CONFIRM);

  localparam logic [STATE_W-1:0] S_IDLE  = ST_IDLE;
  localparam logic [STATE_W-1:0] S_DRIP  = ST_DRIP;
  localparam logic [STATE_W-1:0] S_SPRAY = ST_SPRAY;
  localparam logic [STATE_W-1:0] S_DEAD  = ST_DEAD;
  localparam logic [STATE_W-1:0] S_LOCK  = ST_LOCK;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] target_q, target_d;
  logic [TW-1:0]      timer_q, timer_d, timer_dec;
  logic [EW-1:0]      err_q, err_d;
  logic               lock_hit;
  logic               vs_q, bs_q, ve_q, lock_q;
  logic               blink;

  // Saturating count of consecutive err_in cycles; reaching the limit forces LOCK.
  always_comb begin
    err_d = '0;
    if (err_in) begin
      err_d = (err_q == E_MAX) ? err_q : err_q + EW'(1);
    end
  end

  assign lock_hit  = (err_d == E_MAX);
  assign timer_dec = (timer_q == '0) ? timer_q : timer_q - TW'(1);

  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (!vazio_in) begin
          if (vs_req) begin
            state_d = S_DRIP;
            timer_d = T_MIN_ON;
          end else if (bs_req) begin
            state_d = S_SPRAY;
            timer_d = T_MIN_ON;
          end
        end
      end
      S_DRIP: begin
        timer_d = timer_dec;
        if (vazio_in) begin
          state_d = S_IDLE;
        end else if (timer_q == '0 && !vs_req) begin
          state_d  = S_DEAD;
          timer_d  = T_DEAD;
          target_d = bs_req ? S_SPRAY : S_IDLE;
        end
      end
      S_SPRAY: begin
        timer_d = timer_dec;
        if (vazio_in) begin
          state_d = S_IDLE;
        end else if (timer_q == '0 && !bs_req) begin
          state_d  = S_DEAD;
          timer_d  = T_DEAD;
          target_d = vs_req ? S_DRIP : S_IDLE;
        end
      end
      S_DEAD: begin
        timer_d = timer_dec;
        if (timer_q == '0) begin
          if (!vazio_in && ((target_q == S_DRIP && vs_req) || (target_q == S_SPRAY && bs_req))) begin
            state_d = target_q;
            timer_d = T_MIN_ON;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOCK: begin
        if (ack && !err_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Confirmed sensor error wins over everything, including minimum on-time.
    if (lock_hit) begin
      state_d = S_LOCK;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= S_IDLE;
      timer_q  <= '0;
      err_q    <= '0;
      vs_q     <= 1'b0;
      bs_q     <= 1'b0;
      ve_q     <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      vs_q     <= (state_d == S_DRIP);
      bs_q     <= (state_d == S_SPRAY);
      ve_q     <= ve_req && (state_d != S_LOCK);
      lock_q   <= (state_d == S_LOCK);
    end
  end

  alarm_blinker #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blinker (
    .clk  (clk),
    .reset(reset),
    .en   (al_req),
    .blink(blink)
  );

  assign vs_out  = vs_q;
  assign bs_out  = bs_q;
  assign ve_out  = ve_q;
  assign lockout = lock_q;
  // Lamp is solid while locked, otherwise the blinker flop.
  assign al_out  = lock_q | blink;
  assign state_o = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed-vector bench for irrigation_sequencer with default parameters.
module tb_irrigation_sequencer;

  logic       clk = 1'b0;
  logic       reset, vs_req, bs_req, ve_req, al_req, err_in, vazio_in, ack;
  logic       vs_out, bs_out, ve_out, al_out, lockout;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  irrigation_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .vs_req  (vs_req),
    .bs_req  (bs_req),
    .ve_req  (ve_req),
    .al_req  (al_req),
    .err_in  (err_in),
    .vazio_in(vazio_in),
    .ack     (ack),
    .vs_out  (vs_out),
    .bs_out  (bs_out),
    .ve_out  (ve_out),
    .al_out  (al_out),
    .lockout (lockout),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [4:0] exp_vbval, input logic [2:0] exp_st);
    check({tag, ".outs"}, {27'd0, vs_out, bs_out, ve_out, al_out, lockout}, {27'd0, exp_vbval});
    check({tag, ".state"}, {29'd0, state_o}, {29'd0, exp_st});
  endtask

  logic [15:0] blink_pat;

  initial begin
    reset = 1'b1; vs_req = 1'b0; bs_req = 1'b0; ve_req = 1'b0;
    al_req = 1'b0; err_in = 1'b0; vazio_in = 1'b0; ack = 1'b0;
    tick(); tick();
    check_outs("reset", 5'b00000, 3'd0);
    reset = 1'b0;
    tick();

    // 1-cycle drip pulse: exactly 8 cycles of vs_out, then dead-time, then idle
    vs_req = 1'b1;
    tick();
    vs_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("drip_pulse.vs", {31'd0, vs_out}, 32'd1);
      check("drip_pulse.bs", {31'd0, bs_out}, 32'd0);
      tick();
    end
    check("drip_pulse.vs_off", {31'd0, vs_out}, 32'd0);
    check("drip_pulse.dead", {29'd0, state_o}, 32'd3);
    tick(); tick();
    check("drip_pulse.idle", {29'd0, state_o}, 32'd0);

    // Drip -> spray handover at cycle 3 of drip
    vs_req = 1'b1;
    tick();
    check("handover.vs1", {31'd0, vs_out}, 32'd1);
    tick(); tick();
    vs_req = 1'b0; bs_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("handover.vs_hold", {30'd0, vs_out, bs_out}, 32'b10);
    end
    tick();
    check("handover.dead1", {30'd0, vs_out, bs_out}, 32'b00);
    tick();
    check("handover.dead2", {30'd0, vs_out, bs_out}, 32'b00);
    tick();
    check_outs("handover.spray", 5'b01000, 3'd2);

    // Tank empty during spray minimum on-time
    tick();
    vazio_in = 1'b1;
    tick();
    check_outs("vazio", 5'b00000, 3'd0);
    vazio_in = 1'b0; bs_req = 1'b0;
    tick();
    check_outs("vazio.stay", 5'b00000, 3'd0);

    // Error bursts 2 / gap / 3, lockout and acknowledge handling
    ve_req = 1'b1;
    err_in = 1'b1;
    tick(); tick();
    check("err.burst1", {31'd0, lockout}, 32'd0);
    err_in = 1'b0;
    tick();
    check_outs("err.gap", 5'b00100, 3'd0);
    err_in = 1'b1;
    tick(); tick();
    check("err.burst2_2", {31'd0, lockout}, 32'd0);
    tick();
    check_outs("err.lock", 5'b00011, 3'd4);
    ack = 1'b1;
    tick();
    check_outs("err.ack_ignored", 5'b00011, 3'd4);
    err_in = 1'b0;
    tick();
    check_outs("err.release", 5'b00100, 3'd0);
    ack = 1'b0; ve_req = 1'b0;
    tick();

    // Alarm blink pattern over 16 cycles, then off
    blink_pat = 16'b1111_0000_1111_0000;
    al_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("blink[%0d]", i), {31'd0, al_out}, {31'd0, blink_pat[15-i]});
    end
    al_req = 1'b0;
    tick();
    check("blink.off", {31'd0, al_out}, 32'd0);

    // Reset during drip, then full minimum on-time restart
    ve_req = 1'b1; vs_req = 1'b1;
    tick(); tick();
    check_outs("rst_mid.pre", 5'b10100, 3'd1);
    reset = 1'b1;
    tick();
    check_outs("rst_mid.reset", 5'b00000, 3'd0);
    reset = 1'b0; ve_req = 1'b0;
    tick();
    vs_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("rst_mid.vs", {30'd0, vs_out, bs_out}, 32'b10);
      tick();
    end
    check("rst_mid.vs_off", {31'd0, vs_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
Downstream actuator stage of the irrigation controller. It consumes the combinational decision outputs: drip request, spray request, inlet-valve request, alarm, error and empty-tank flags. It drives the physical drip valve, sprinkler valve, inlet valve and alarm lamp with enforced timing: minimum on-time, dead-time between modes, error lockout and alarm blinking. Drip and spray are never driven simultaneously.

Parameters:
MIN_ON, 8, minimum cycles a drip/spray valve stays open once opened (>=1)
DEAD, 2, cycles with both irrigation valves closed when switching drip<->spray (>=1)
ERR_CONFIRM, 3, consecutive cycles of err_in required to enter lockout (>=1)
BLINK_DIV, 4, alarm lamp half-period in cycles (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
vs_req  input  1  drip (gotejamento) request
bs_req  input  1  spray (aspersao) request
ve_req  input  1  inlet valve request
al_req  input  1  alarm request
err_in  input  1  level-sensor inconsistency flag
vazio_in  input  1  tank empty flag
ack  input  1  operator lockout acknowledge
vs_out  output  1  drip valve drive (registered)
bs_out  output  1  sprinkler valve drive (registered)
ve_out  output  1  inlet valve drive (registered)
al_out  output  1  alarm lamp drive (registered)
lockout  output  1  high while in LOCK
state_o  output  3  current state encoding, for debug

Behaviour:
- Reset: state IDLE. All outputs are 0. The timer, error counter and blink counter are all 0. Reset asserted mid-operation closes all valves at the next edge.
- All outputs are registered. A request sampled high at edge n is reflected at edge n+1 at the earliest.
- States: IDLE=0, DRIP=1, SPRAY=2, DEAD=3, LOCK=4.
- Error counter: increments while err_in=1 and saturates at ERR_CONFIRM. Any cycle with err_in=0 clears it.
- Lockout entry: when the counter reaches ERR_CONFIRM, the next state is LOCK from any state. This has the highest priority and overrides MIN_ON.
- IDLE, when vazio_in=0:
  - vs_req=1 -> DRIP.
  - else bs_req=1 -> SPRAY.
  - Drip has priority if both are high.
  - On entry the timer is loaded with MIN_ON-1.
- DRIP: vs_out=1.
  - The timer decrements to 0.
  - Exit is allowed only when timer=0 and vs_req=0. Then go to DEAD with target SPRAY if bs_req=1, else IDLE.
  - vazio_in=1 forces IDLE immediately (dry-run protection overrides MIN_ON).
- SPRAY: symmetric to DRIP with bs_out=1. The exit target is DRIP if vs_req=1.
- DEAD: vs_out=bs_out=0 for exactly DEAD cycles (timer loaded with DEAD-1).
  - When done: if the target's request is still high and vazio_in=0, go to the target and load MIN_ON-1. Otherwise go to IDLE.
- LOCK:
  - vs_out=bs_out=ve_out=0, al_out=1 solid, lockout=1.
  - Exit to IDLE only on a cycle with ack=1 and err_in=0.
  - ack while err_in=1 is ignored.
- ve_out: equals the registered ve_req in every state except LOCK (forced 0). It is independent of the drip/spray FSM.
- al_out outside LOCK:
  - While al_req=1, it toggles every BLINK_DIV cycles, starting high one cycle after al_req rises.
  - While al_req=0, it is 0 and the blink counter is cleared.
- Invariant: vs_out & bs_out is never 1.
- Timer width is $clog2(max(MIN_ON,DEAD)+1). Blink counter width is $clog2(BLINK_DIV+1).

Decomposition:
- Package irrigation_pkg: state enum (IDLE, DRIP, SPRAY, DEAD, LOCK), 3-bit state width constant, default parameter constants.
- One sub-module, alarm_blinker (clk, reset, en, BLINK_DIV -> blink): holds the blink counter and toggle flop. The sequencer gates its output with the LOCK override.

Test Plan:
- vs_req pulsed high for 1 cycle from IDLE -> vs_out=1 for exactly 8 cycles, then 0; bs_out stays 0 throughout.
- In DRIP, drop vs_req and raise bs_req at cycle 3 -> vs_out holds through cycle 8, then both low for exactly 2 cycles, then bs_out=1.
- In SPRAY at cycle 2, assert vazio_in -> bs_out=0 at the next edge (MIN_ON overridden); state_o=0.
- err_in high for 2 cycles, low 1, high 3 -> no lockout after the first burst. Lockout=1 after the 3rd consecutive cycle of the second burst; all valves 0, al_out=1. ack with err_in=1 -> stays locked. ack with err_in=0 -> IDLE.
- al_req held high for 16 cycles, no error -> al_out pattern 1111 0000 1111 0000. al_req low -> al_out=0 the next cycle.
- Assert reset during DRIP with ve_req=1 -> all outputs 0 at the next edge; after release with vs_req=1, drip restarts with a full 8-cycle minimum.
